// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths, arbiter state encodings and the RAM hold
// code used by the data-RAM arbiter and by hold_ctrl.
package ram_arbiter_pkg;

    // Data RAM geometry (word-addressed, 256 words of 32 bits)
    localparam int RAM_ADDR_W  = 8;
    localparam int RAM_DATA_W  = 32;

    // Arbiter state and burst counter widths
    localparam int ARB_STATE_W = 2;
    localparam int ARB_CNT_W   = 4;

    // Arbiter states
    localparam logic [ARB_STATE_W-1:0] ARB_IDLE = 2'd0;
    localparam logic [ARB_STATE_W-1:0] ARB_MST  = 2'd1;
    localparam logic [ARB_STATE_W-1:0] ARB_CORE = 2'd2;

    // Hold type codes seen by hold_ctrl; HOLD_RAM marks a stall caused by a
    // master owning the data RAM
    localparam int HOLD_TYPE_W = 3;
    localparam logic [HOLD_TYPE_W-1:0] HOLD_NONE = 3'b000;
    localparam logic [HOLD_TYPE_W-1:0] HOLD_RAM  = 3'b100;

endpackage

// File: rtl/ram_arbiter_burst_cnt.sv
// arb_burst_cnt: counts consecutive master grants that stall a waiting core
// and requests a forced core turn when the count reaches MAX_BURST.
// Only instantiated when RAM_ARB_FAIR_EN is defined.
module arb_burst_cnt
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
)
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_gnt,
    input  logic i_core_req,
    output logic o_force_core
);

    localparam logic [ARB_CNT_W-1:0] BurstLimit = ARB_CNT_W'(MAX_BURST);

    logic [ARB_CNT_W-1:0] cnt_q;
    logic [ARB_CNT_W-1:0] cnt_d;
    logic [ARB_CNT_W-1:0] cntInc;
    logic                 forceCore;

    // Count stalling grants; hitting the limit forces a core turn and restarts the count
    always_comb begin
        cntInc    = cnt_q + 4'd1;
        cnt_d     = '0;
        forceCore = 1'b0;
        if (i_gnt && i_core_req) begin
            if (cntInc == BurstLimit) begin
                forceCore = 1'b1;
            end else begin
                cnt_d = cntInc;
            end
        end
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_force_core = forceCore;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the core execute
// stage and an external bus master. The master wins each cycle it requests
// and the core is held meanwhile. With RAM_ARB_FAIR_EN defined (which also
// adds the MAX_BURST parameter), a bounded-burst counter forces one core
// turn after MAX_BURST consecutive stalling grants; otherwise the master has
// strict priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
`ifdef RAM_ARB_FAIR_EN
#(
    parameter int MAX_BURST = 4
)
`endif
(
    input  logic                  i_clk,
    input  logic                  i_reset,

    input  logic                  i_core_req,
    input  logic                  i_core_we,
    input  logic [RAM_ADDR_W-1:0] i_core_r_addr,
    input  logic [RAM_ADDR_W-1:0] i_core_w_addr,
    input  logic [RAM_DATA_W-1:0] i_core_w_data,
    output logic [RAM_DATA_W-1:0] o_core_r_data,
    output logic                  o_hold_req,

    input  logic                  i_m_req,
    input  logic                  i_m_we,
    input  logic [RAM_ADDR_W-1:0] i_m_addr,
    input  logic [RAM_DATA_W-1:0] i_m_w_data,
    output logic                  o_m_gnt,
    output logic                  o_m_rvalid,
    output logic [RAM_DATA_W-1:0] o_m_r_data,

    output logic                  o_ram_we,
    output logic [RAM_ADDR_W-1:0] o_ram_r_addr,
    output logic [RAM_ADDR_W-1:0] o_ram_w_addr,
    output logic [RAM_DATA_W-1:0] o_ram_w_data,
    input  logic [RAM_DATA_W-1:0] i_ram_r_data
);

    logic [ARB_STATE_W-1:0] state_q;
    logic [ARB_STATE_W-1:0] state_d;
    logic                   rvalid_q;
    logic                   rvalid_d;
    logic [RAM_DATA_W-1:0]  rdata_q;
    logic [RAM_DATA_W-1:0]  rdata_d;
    logic                   mstOwns;
    logic                   forceCore;

`ifdef RAM_ARB_FAIR_EN
    arb_burst_cnt #(
        .MAX_BURST    (MAX_BURST)
    ) u_burst_cnt (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_gnt        (mstOwns),
        .i_core_req   (i_core_req),
        .o_force_core (forceCore)
    );
`else
    assign forceCore = 1'b0;
`endif

    // Owner decision and RAM port steering; nothing is granted or written while in reset
    always_comb begin
        mstOwns      = i_reset && i_m_req && (state_q != ARB_CORE);
        o_m_gnt      = mstOwns;
        o_hold_req   = mstOwns && i_core_req;
        if (mstOwns) begin
            o_ram_we     = i_m_we;
            o_ram_r_addr = i_m_addr;
            o_ram_w_addr = i_m_addr;
            o_ram_w_data = i_m_w_data;
        end else begin
            o_ram_we     = i_reset && i_core_we && i_core_req;
            o_ram_r_addr = i_core_r_addr;
            o_ram_w_addr = i_core_w_addr;
            o_ram_w_data = i_core_w_data;
        end
    end

    // Next state: a forced core turn lasts one cycle, otherwise track whether the master was granted
    always_comb begin
        state_d = ARB_IDLE;
        if (state_q == ARB_CORE) begin
            state_d = i_m_req ? ARB_MST : ARB_IDLE;
        end else if (mstOwns) begin
            state_d = forceCore ? ARB_CORE : ARB_MST;
        end
    end

    // Master read return: capture RAM data on a granted read, present it the next cycle
    always_comb begin
        rvalid_d = mstOwns && !i_m_we;
        rdata_d  = rvalid_d ? i_ram_r_data : rdata_q;
    end

    // State and read-return registers; reset drops any pending read
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ARB_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_core_r_data = i_ram_r_data;
    assign o_m_rvalid    = rvalid_q;
    assign o_m_r_data    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural data RAM.
// Expected contention patterns follow RAM_ARB_FAIR_EN (MAX_BURST = 4).
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic                  clk;
    logic                  rstN;
    logic                  coreReq;
    logic                  coreWe;
    logic [RAM_ADDR_W-1:0] coreRAddr;
    logic [RAM_ADDR_W-1:0] coreWAddr;
    logic [RAM_DATA_W-1:0] coreWData;
    logic [RAM_DATA_W-1:0] coreRData;
    logic                  holdReq;
    logic                  mReq;
    logic                  mWe;
    logic [RAM_ADDR_W-1:0] mAddr;
    logic [RAM_DATA_W-1:0] mWData;
    logic                  mGnt;
    logic                  mRvalid;
    logic [RAM_DATA_W-1:0] mRData;
    logic                  ramWe;
    logic [RAM_ADDR_W-1:0] ramRAddr;
    logic [RAM_ADDR_W-1:0] ramWAddr;
    logic [RAM_DATA_W-1:0] ramWData;
    logic [RAM_DATA_W-1:0] ramRData;

    logic [RAM_DATA_W-1:0] mem [0:255];

    int errors;
    int checks;

`ifdef RAM_ARB_FAIR_EN
    ram_arbiter #(
        .MAX_BURST     (4)
    ) dut (
`else
    ram_arbiter dut (
`endif
        .i_clk         (clk),
        .i_reset       (rstN),
        .i_core_req    (coreReq),
        .i_core_we     (coreWe),
        .i_core_r_addr (coreRAddr),
        .i_core_w_addr (coreWAddr),
        .i_core_w_data (coreWData),
        .o_core_r_data (coreRData),
        .o_hold_req    (holdReq),
        .i_m_req       (mReq),
        .i_m_we        (mWe),
        .i_m_addr      (mAddr),
        .i_m_w_data    (mWData),
        .o_m_gnt       (mGnt),
        .o_m_rvalid    (mRvalid),
        .o_m_r_data    (mRData),
        .o_ram_we      (ramWe),
        .o_ram_r_addr  (ramRAddr),
        .o_ram_w_addr  (ramWAddr),
        .o_ram_w_data  (ramWData),
        .i_ram_r_data  (ramRData)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port data RAM: synchronous write, combinational read
    always @(posedge clk) begin
        if (ramWe) mem[ramWAddr] <= ramWData;
    end
    assign ramRData = mem[ramRAddr];

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive every DUT input, then let combinational outputs settle
    task automatic applyStimulus(input logic cReq, input logic cWe,
                                 input logic [RAM_ADDR_W-1:0] cRAddr,
                                 input logic [RAM_ADDR_W-1:0] cWAddr,
                                 input logic [RAM_DATA_W-1:0] cWData,
                                 input logic req, input logic we,
                                 input logic [RAM_ADDR_W-1:0] addr,
                                 input logic [RAM_DATA_W-1:0] wData);
        coreReq   = cReq;
        coreWe    = cWe;
        coreRAddr = cRAddr;
        coreWAddr = cWAddr;
        coreWData = cWData;
        mReq      = req;
        mWe       = we;
        mAddr     = addr;
        mWData    = wData;
        #1;
    endtask

    // Reset values and output gating while reset is held, then release
    task automatic test_reset();
        rstN = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h05, 32'h1, 1'b1, 1'b1, 8'h06, 32'h2);
        checks++; if (mGnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt got=%b want=0", mGnt); end
        checks++; if (holdReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold got=%b want=0", holdReq); end
        checks++; if (ramWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we got=%b want=0", ramWe); end
        checks++; if (mRvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got=%b want=0", mRvalid); end
        checks++; if (mRData !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got=%h want=00000000", mRData); end
        checks++; if (dut.state_q !== ARB_IDLE) begin errors++; $display("[TB] FAIL reset_state got=%0d want=%0d", dut.state_q, ARB_IDLE); end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        nextCycle();
        rstN = 1'b1;
        #1;
    endtask

    // Core store then load with no master traffic
    task automatic test_core_only();
        nextCycle();
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h0);
        checks++; if (holdReq !== 1'b0) begin errors++; $display("[TB] FAIL core_store_hold got=%b want=0", holdReq); end
        checks++; if (ramWe !== 1'b1) begin errors++; $display("[TB] FAIL core_store_we got=%b want=1", ramWe); end
        checks++; if (ramWAddr !== 8'h10) begin errors++; $display("[TB] FAIL core_store_addr got=%h want=10", ramWAddr); end
        checks++; if (ramWData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL core_store_data got=%h want=deadbeef", ramWData); end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        checks++; if (ramRAddr !== 8'h10) begin errors++; $display("[TB] FAIL core_load_addr got=%h want=10", ramRAddr); end
        checks++; if (coreRData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL core_load_data got=%h want=deadbeef", coreRData); end
        checks++; if (holdReq !== 1'b0) begin errors++; $display("[TB] FAIL core_load_hold got=%b want=0", holdReq); end
        checks++; if (ramWe !== 1'b0) begin errors++; $display("[TB] FAIL core_load_we got=%b want=0", ramWe); end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // Master write to 0x20, then a one-cycle master read of 0x20
    task automatic test_master_read();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b1, 1'b1, 8'h20, 32'h12345678);
        checks++; if (mGnt !== 1'b1) begin errors++; $display("[TB] FAIL mwrite_gnt got=%b want=1", mGnt); end
        checks++; if (ramWe !== 1'b1) begin errors++; $display("[TB] FAIL mwrite_we got=%b want=1", ramWe); end
        checks++; if (ramWAddr !== 8'h20) begin errors++; $display("[TB] FAIL mwrite_addr got=%h want=20", ramWAddr); end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
        checks++; if (mGnt !== 1'b1) begin errors++; $display("[TB] FAIL mread_gnt got=%b want=1", mGnt); end
        checks++; if (mRvalid !== 1'b0) begin errors++; $display("[TB] FAIL mread_rvalid_early got=%b want=0", mRvalid); end
        checks++; if (holdReq !== 1'b0) begin errors++; $display("[TB] FAIL mread_hold got=%b want=0", holdReq); end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        checks++; if (mRvalid !== 1'b1) begin errors++; $display("[TB] FAIL mread_rvalid got=%b want=1", mRvalid); end
        checks++; if (mRData !== 32'h12345678) begin errors++; $display("[TB] FAIL mread_data got=%h want=12345678", mRData); end
        checks++; if (mGnt !== 1'b0) begin errors++; $display("[TB] FAIL mread_gnt_idle got=%b want=0", mGnt); end
        nextCycle();
        checks++; if (mRvalid !== 1'b0) begin errors++; $display("[TB] FAIL mread_rvalid_once got=%b want=0", mRvalid); end
    endtask

    // Four master writes, then four back-to-back reads returning data every cycle
    task automatic test_back_to_back();
        logic [RAM_DATA_W-1:0] want;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b1, 1'b1, 8'h30 + 8'(i), 32'hA5A50000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b1, 1'b0, 8'h30 + 8'(i), 32'h0);
            if (i > 0) begin
                want = 32'hA5A50000 + 32'(i - 1);
                checks++; if (mRvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rvalid[%0d] got=%b want=1", i - 1, mRvalid); end
                checks++; if (mRData !== want) begin errors++; $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", i - 1, mRData, want); end
            end
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        checks++; if (mRvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rvalid[3] got=%b want=1", mRvalid); end
        checks++; if (mRData !== 32'hA5A50003) begin errors++; $display("[TB] FAIL b2b_data[3] got=%h want=a5a50003", mRData); end
    endtask

    // Core and master both requesting for ten cycles
    task automatic test_contention();
        logic [9:0] pattern;
        logic       want;
`ifdef RAM_ARB_FAIR_EN
        pattern = 10'b1111011110;
`else
        pattern = 10'b1111111111;
`endif
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 32'h0, 1'b1, 1'b1, 8'h40, 32'(c));
            want = pattern[9 - c];
            checks++; if (mGnt !== want) begin errors++; $display("[TB] FAIL contend_gnt[%0d] got=%b want=%b", c, mGnt, want); end
            checks++; if (holdReq !== want) begin errors++; $display("[TB] FAIL contend_hold[%0d] got=%b want=%b", c, holdReq, want); end
            checks++; if (ramWe !== want) begin errors++; $display("[TB] FAIL contend_we[%0d] got=%b want=%b", c, ramWe, want); end
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        nextCycle();
    endtask

    // Reset asserted the cycle after a master read grant drops the pending data
    task automatic test_reset_mid_read();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
        checks++; if (mGnt !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_gnt got=%b want=1", mGnt); end
        nextCycle();
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
        checks++; if (mRvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rvalid got=%b want=0", mRvalid); end
        checks++; if (mRData !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_rdata got=%h want=00000000", mRData); end
        checks++; if (dut.state_q !== ARB_IDLE) begin errors++; $display("[TB] FAIL rstmid_state got=%0d want=%0d", dut.state_q, ARB_IDLE); end
        checks++; if (mGnt !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_gnt_held got=%b want=0", mGnt); end
        nextCycle();
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 32'h0, 1'b0, 1'b0, 8'h20, 32'h0);
        checks++; if (mGnt !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_gnt got=%b want=0", mGnt); end
        checks++; if (holdReq !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_hold got=%b want=0", holdReq); end
        checks++; if (ramRAddr !== 8'h10) begin errors++; $display("[TB] FAIL rstrel_addr got=%h want=10", ramRAddr); end
        checks++; if (coreRData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rstrel_data got=%h want=deadbeef", coreRData); end
        checks++; if (mRvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_rvalid got=%b want=0", mRvalid); end
    endtask

    // Scenario sequence and summary
    initial begin
        errors = 0;
        checks = 0;
        rstN   = 1'b0;
        test_reset();
        test_core_only();
        test_master_read();
        test_back_to_back();
        test_contention();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port data RAM between the core's execute stage and one external bus master (program loader / debug port). Core load/store traffic passes through untouched when the master is idle. Master accesses are granted per cycle and stall the core through a hold request to hold_ctrl. A bounded-burst rule guarantees the core forward progress.

## Interface
Parameters:
- MAX_BURST, 4, consecutive master grants allowed while the core is waiting (1..15).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_core_req  in  1  ex is executing a load/store this cycle.
- i_core_we  in  1  ex store enable (ex o_mem_we).
- i_core_r_addr  in  `RAMAddrBus`  ex read address.
- i_core_w_addr  in  `RAMAddrBus`  ex write address.
- i_core_w_data  in  `RAMDataBus`  ex write data.
- o_core_r_data  out  `RAMDataBus`  RAM read data to ex.
- o_hold_req  out  1  to hold_ctrl: freeze the pipeline this cycle.
- i_m_req  in  1  master request.
- i_m_we  in  1  master write.
- i_m_addr  in  `RAMAddrBus`  master address.
- i_m_w_data  in  `RAMDataBus`  master write data.
- o_m_gnt  out  1  master access performed this cycle.
- o_m_rvalid  out  1  master read data valid.
- o_m_r_data  out  `RAMDataBus`  master read data.
- o_ram_we, o_ram_r_addr, o_ram_w_addr, o_ram_w_data  out  1 / `RAMAddrBus` / `RAMAddrBus` / `RAMDataBus`  to data_ram.
- i_ram_r_data  in  `RAMDataBus`  combinational read data from data_ram.

## Operation
- States:
  - ARB_IDLE: no master activity.
  - ARB_MST: master owned the previous cycle.
  - ARB_CORE: forced core turn.
- Per-cycle owner:
  - Master if i_m_req and state != ARB_CORE.
  - Otherwise core.
- Master owns:
  - RAM ports are driven from i_m_*.
  - o_m_gnt=1.
  - o_hold_req=i_core_req.
  - o_ram_we=i_m_we.
- Core owns:
  - RAM ports are driven from i_core_*.
  - o_m_gnt=0.
  - o_hold_req=0.
  - o_ram_we=i_core_we & i_core_req.
- o_core_r_data=i_ram_r_data always. The core ignores it while held.
- Master read on a granted cycle with i_m_we=0: i_ram_r_data is registered into o_m_r_data, and o_m_rvalid=1 on the next cycle only.
- Burst counter (4 bits):
  - Increments on each grant while i_core_req=1.
  - Clears on any cycle the core owns or i_core_req=0.
  - When a grant would bring it to MAX_BURST, the next state is ARB_CORE.
- ARB_CORE lasts exactly one cycle, then goes to ARB_MST if i_m_req, else ARB_IDLE.
- Transitions from ARB_IDLE/ARB_MST: grant → ARB_MST (or ARB_CORE per the counter); no grant → ARB_IDLE.
- A denied master holds i_m_req and its address/data stable until o_m_gnt.

## Timing
- Grant and hold decisions are combinational from the inputs and the current state. There is no added latency on the core path.
- Master write completes in the grant cycle. Master read data arrives 1 cycle after the grant.
- Back-to-back master reads produce o_m_rvalid every cycle.
- Reset values: state ARB_IDLE, counter 0, o_m_rvalid=0, o_m_r_data=0. While i_reset=0: o_m_gnt=0, o_hold_req=0, o_ram_we=0.
- Reset asserted mid-burst aborts the burst. A pending rvalid is dropped, and the master must re-request.
- Simultaneous core and master requests: master wins, except in ARB_CORE.
- Counter saturation: it never exceeds MAX_BURST, and it is cleared on entry to ARB_CORE.

## Configuration
- RAM_ARB_FAIR_EN defined: bounded-burst counter and ARB_CORE state are present, as described above.
- RAM_ARB_FAIR_EN undefined: strict master priority. No counter, ARB_CORE is unreachable and removed, and the core can be held indefinitely.

## Structure
- defines.v gains:
  - `ArbStateBus` and the state encodings ARB_IDLE/ARB_MST/ARB_CORE.
  - `ArbCntBus` (3:0).
  - A new `HoldTypeBus` code for the RAM hold, consumed by hold_ctrl.
- One sub-module, arb_burst_cnt: the counter plus the force-core decision. It is instantiated only under RAM_ARB_FAIR_EN.

## Test plan
- Core only: i_core_req=1, store 0xDEADBEEF at address 0x10, then load 0x10.
  - Response: the RAM sees the core ports, o_hold_req=0 throughout, and the load returns 0xDEADBEEF.
- Master read: preload 0x12345678 at 0x20, then i_m_req=1 with i_m_addr=0x20 for 1 cycle.
  - Response: o_m_gnt=1 in the grant cycle, then o_m_rvalid=1 with o_m_r_data=0x12345678 the next cycle.
- Contention: i_core_req=1 and i_m_req=1 held for 10 cycles with MAX_BURST=4, RAM_ARB_FAIR_EN defined.
  - o_m_gnt pattern: 1111 0 1111 0.
  - o_hold_req equals o_m_gnt each cycle.
- Strict priority: same stimulus with RAM_ARB_FAIR_EN undefined.
  - o_m_gnt=1 and o_hold_req=1 for all 10 cycles.
- Reset mid-read: assert i_reset low in the cycle after a master read grant.
  - o_m_rvalid=0, o_m_r_data=0, and state ARB_IDLE immediately.
  - After release, the first cycle without i_m_req gives core ownership.
